// File: rtl/led_seq_ctrl_pkg.sv
// Shared encodings and elaboration helpers for the LED sequencing controller.
package led_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_SOLID = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BURST = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SOLID = 2'd1,
      ST_B_ON  = 2'd2,
      ST_B_OFF = 2'd3
   } state_e;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: emits a one-cycle tick every DIV clocks; clr restarts the count.
module led_tick_gen
   import led_seq_ctrl_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int W = cnt_width(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: OFF / SOLID / continuous BLINK / counted BURST with
// a valid/ready configuration port and registered LED drive.
module led_seq_ctrl
   import led_seq_ctrl_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1_000,
   parameter int N_LED   = 4,
   parameter int PER_W   = 16,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_mode,
   input  logic [N_LED-1:0] cfg_mask,
   input  logic [PER_W-1:0] cfg_half_period,
   input  logic [CNT_W-1:0] cfg_count,
   output logic [N_LED-1:0] led,
   output logic             busy,
   output logic             done
);

   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

   if (DIV < 1) begin : g_bad_div
      $error("led_seq_ctrl: CLK_HZ/TICK_HZ must be at least 1");
   end

   state_e           state;
   logic [N_LED-1:0] mask_q;
   logic [PER_W-1:0] hp_q;
   logic [PER_W-1:0] phase_cnt;
   logic [CNT_W-1:0] burst_left;
   logic             burst_mode;
   logic             tick;
   logic             xfer;

   assign xfer = cfg_valid && cfg_ready;

   // Phase timing restarts from zero on every accepted configuration.
   led_tick_gen #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (xfer),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         led        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cfg_ready  <= 1'b1;
         mask_q     <= '0;
         hp_q       <= '0;
         phase_cnt  <= '0;
         burst_left <= '0;
         burst_mode <= 1'b0;
      end else begin
         done <= 1'b0;
         if (xfer) begin
            mask_q     <= cfg_mask;
            hp_q       <= (cfg_half_period == '0) ? PER_W'(1) : cfg_half_period;
            phase_cnt  <= '0;
            burst_left <= '0;
            burst_mode <= 1'b0;
            case (mode_e'(cfg_mode))
               MODE_OFF: begin
                  state     <= ST_IDLE;
                  led       <= '0;
                  busy      <= 1'b0;
                  cfg_ready <= 1'b1;
               end
               MODE_SOLID: begin
                  state     <= ST_SOLID;
                  led       <= cfg_mask;
                  busy      <= 1'b0;
                  cfg_ready <= 1'b1;
               end
               MODE_BLINK: begin
                  state     <= ST_B_ON;
                  led       <= cfg_mask;
                  busy      <= 1'b1;
                  cfg_ready <= 1'b1;
               end
               MODE_BURST: begin
                  if (cfg_count == '0) begin
                     state     <= ST_IDLE;
                     led       <= '0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     cfg_ready <= 1'b1;
                  end else begin
                     state      <= ST_B_ON;
                     led        <= cfg_mask;
                     busy       <= 1'b1;
                     cfg_ready  <= 1'b0;
                     burst_mode <= 1'b1;
                     burst_left <= cfg_count;
                  end
               end
            endcase
         end else if ((state == ST_B_ON || state == ST_B_OFF) && tick) begin
            if (phase_cnt == hp_q - PER_W'(1)) begin
               phase_cnt <= '0;
               if (state == ST_B_ON) begin
                  state <= ST_B_OFF;
                  led   <= '0;
               end else if (burst_mode && burst_left == CNT_W'(1)) begin
                  // Final OFF phase of a burst: report completion and reopen the port.
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  cfg_ready  <= 1'b1;
                  burst_mode <= 1'b0;
                  burst_left <= '0;
               end else begin
                  state <= ST_B_ON;
                  led   <= mask_q;
                  if (burst_mode) begin
                     burst_left <= burst_left - CNT_W'(1);
                  end
               end
            end else begin
               phase_cnt <= phase_cnt + PER_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with DIV=10 (CLK_HZ=100, TICK_HZ=10), N_LED=4.
module tb_led_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_mode;
   logic [3:0]  cfg_mask;
   logic [15:0] cfg_half_period;
   logic [7:0]  cfg_count;
   logic [3:0]  led;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   led_seq_ctrl #(
      .CLK_HZ  (100),
      .TICK_HZ (10),
      .N_LED   (4),
      .PER_W   (16),
      .CNT_W   (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_mode        (cfg_mode),
      .cfg_mask        (cfg_mask),
      .cfg_half_period (cfg_half_period),
      .cfg_count       (cfg_count),
      .led             (led),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] mode, input logic [3:0] mask,
                       input logic [15:0] hp, input logic [7:0] cnt);
      cfg_mode        = mode;
      cfg_mask        = mask;
      cfg_half_period = hp;
      cfg_count       = cnt;
      cfg_valid       = 1'b1;
      step();
      cfg_valid       = 1'b0;
   endtask

   initial begin
      int bad;
      int bad_led;
      int bad_ctl;
      int n_done;
      logic [3:0] exp_led;

      rst = 1'b1;
      cfg_valid = 1'b0;
      cfg_mode = 2'd0;
      cfg_mask = 4'h0;
      cfg_half_period = 16'd0;
      cfg_count = 8'd0;
      step();
      step();
      rst = 1'b0;
      check("rst_led", led, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ready", cfg_ready, 1'b1);

      // Reset mid-BLINK
      send(2'd2, 4'hF, 16'd3, 8'd0);
      check("blink0_led", led, 4'hF);
      check("blink0_busy", busy, 1'b1);
      repeat (12) step();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      check("rstblink_led", led, 4'h0);
      check("rstblink_busy", busy, 1'b0);
      check("rstblink_done", done, 1'b0);
      check("rstblink_ready", cfg_ready, 1'b1);
      bad = 0;
      for (int i = 0; i < 80; i++) begin
         if (led !== 4'h0 || done !== 1'b0) bad++;
         step();
      end
      check("rst_idle_hold", bad, 0);

      // SOLID
      check("solid_pre_led", led, 4'h0);
      send(2'd1, 4'b1010, 16'd0, 8'd0);
      check("solid_led", led, 4'b1010);
      check("solid_busy", busy, 1'b0);
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         if (led !== 4'b1010 || busy !== 1'b0 || cfg_ready !== 1'b1) bad++;
         step();
      end
      check("solid_hold", bad, 0);

      // Continuous BLINK, 30-cycle phases
      send(2'd2, 4'hF, 16'd3, 8'd0);
      bad_led = 0;
      bad_ctl = 0;
      for (int i = 0; i < 120; i++) begin
         exp_led = (((i / 30) % 2) == 0) ? 4'hF : 4'h0;
         if (led !== exp_led) bad_led++;
         if (busy !== 1'b1 || cfg_ready !== 1'b1 || done !== 1'b0) bad_ctl++;
         step();
      end
      check("blink_pattern", bad_led, 0);
      check("blink_ctl", bad_ctl, 0);
      check("blink_midon_led", led, 4'hF);
      send(2'd0, 4'hF, 16'd3, 8'd0);
      check("off_led", led, 4'h0);
      check("off_busy", busy, 1'b0);

      // BURST: 3 x (20 ON + 20 OFF), competing config held valid throughout
      send(2'd3, 4'b0001, 16'd2, 8'd3);
      cfg_mode = 2'd1;
      cfg_mask = 4'hF;
      cfg_valid = 1'b1;
      bad_led = 0;
      bad_ctl = 0;
      for (int i = 0; i < 120; i++) begin
         exp_led = (((i / 20) % 2) == 0) ? 4'b0001 : 4'b0000;
         if (led !== exp_led) bad_led++;
         if (busy !== 1'b1 || cfg_ready !== 1'b0 || done !== 1'b0) bad_ctl++;
         step();
      end
      cfg_valid = 1'b0;
      check("burst_pattern", bad_led, 0);
      check("burst_ctl", bad_ctl, 0);
      check("burst_done", done, 1'b1);
      check("burst_busy_end", busy, 1'b0);
      check("burst_ready_end", cfg_ready, 1'b1);
      check("burst_led_end", led, 4'h0);
      step();
      check("burst_done_pulse", done, 1'b0);
      check("burst_idle_led", led, 4'h0);

      // BURST with count=0
      send(2'd3, 4'hF, 16'd2, 8'd0);
      check("burst0_done", done, 1'b1);
      check("burst0_led", led, 4'h0);
      check("burst0_busy", busy, 1'b0);
      step();
      check("burst0_done_pulse", done, 1'b0);

      // half_period=0 acts as 1: 10-cycle phases
      send(2'd2, 4'b0011, 16'd0, 8'd0);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         exp_led = (((i / 10) % 2) == 0) ? 4'b0011 : 4'b0000;
         if (led !== exp_led) bad++;
         step();
      end
      check("hp0_pattern", bad, 0);
      send(2'd0, 4'h0, 16'd0, 8'd0);

      // Reset during the second OFF phase of a burst
      send(2'd3, 4'b0010, 16'd2, 8'd3);
      repeat (65) step();
      check("midburst_led_off", led, 4'h0);
      check("midburst_busy", busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midburst_rst_led", led, 4'h0);
      check("midburst_rst_busy", busy, 1'b0);
      check("midburst_rst_ready", cfg_ready, 1'b1);
      n_done = 0;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (done === 1'b1) n_done++;
         if (led !== 4'h0) bad++;
         step();
      end
      check("midburst_no_done", n_done, 0);
      check("midburst_led_idle", bad, 0);
      send(2'd2, 4'b0100, 16'd1, 8'd0);
      check("restart_led", led, 4'b0100);
      check("restart_busy", busy, 1'b1);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         exp_led = (((i / 10) % 2) == 0) ? 4'b0100 : 4'b0000;
         if (led !== exp_led) bad++;
         step();
      end
      check("restart_pattern", bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
